// File: rtl/mcht_enc.sv
// Manchester line transmitter: idle-high, sync symbol (low half then high half), then pMSG_LEN data symbols LSB-first.
// Latency: TXD falls the clock after accept; frame is 2*pHALF*(pMSG_LEN+1) clocks, then at least pGAP idle-high clocks.
// Backpressure: MSG_RDY is registered from state only; one word per frame, MSG/MSG_VLD ignored while busy.
module mcht_enc #(
    parameter int pMSG_LEN = 8,
    parameter int pHALF    = 4,
    parameter int pGAP     = 24
) (
    input  logic                CLK125M,
    input  logic                RST_N,
    input  logic [pMSG_LEN-1:0] MSG,
    input  logic                MSG_VLD,
    output logic                MSG_RDY,
    output logic                TXD,
    output logic                TX_BUSY,
    output logic                TX_DONE
);

    localparam int HW = (pHALF > 1) ? $clog2(pHALF) : 1;
    localparam int IW = (pMSG_LEN > 1) ? $clog2(pMSG_LEN) : 1;
    localparam int GW = $clog2(pGAP + 1);

    localparam logic [HW-1:0] HALF_LAST = HW'(pHALF - 1);
    localparam logic [HW-1:0] HALF_PRE  = HW'(pHALF - 2);
    localparam logic [IW-1:0] IDX_LAST  = IW'(pMSG_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(pGAP - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(pGAP);

    typedef enum logic [2:0] {
        eIDLE    = 3'd0,
        eSYNC_LO = 3'd1,
        eSYNC_HI = 3'd2,
        eBIT_H1  = 3'd3,
        eBIT_H2  = 3'd4,
        eGAP     = 3'd5
    } state_t;

    state_t              state;
    logic [HW-1:0]       half_cnt;
    logic [IW-1:0]       bit_idx;
    logic [GW-1:0]       gap_cnt;
    logic [pMSG_LEN-1:0] shift_reg;
    logic [pMSG_LEN-1:0] shift_nxt;
    logic                half_end;

    assign shift_nxt = shift_reg >> 1;
    assign half_end  = (half_cnt == HALF_LAST);

    always_ff @(posedge CLK125M or negedge RST_N) begin
        if (!RST_N) begin
            state     <= eGAP;
            half_cnt  <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            shift_reg <= '0;
            TXD       <= 1'b1;
            MSG_RDY   <= 1'b0;
            TX_BUSY   <= 1'b1;
            TX_DONE   <= 1'b0;
        end else begin
            TX_DONE <= 1'b0;
            case (state)
                eIDLE: begin
                    TXD <= 1'b1;
                    if (MSG_VLD && MSG_RDY) begin
                        shift_reg <= MSG;
                        bit_idx   <= '0;
                        half_cnt  <= '0;
                        TXD       <= 1'b0;
                        MSG_RDY   <= 1'b0;
                        TX_BUSY   <= 1'b1;
                        state     <= eSYNC_LO;
                    end
                end
                eSYNC_LO: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        TXD      <= 1'b1;
                        state    <= eSYNC_HI;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                eSYNC_HI: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        TXD      <= ~shift_reg[0];
                        state    <= eBIT_H1;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                eBIT_H1: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        TXD      <= shift_reg[0];
                        state    <= eBIT_H2;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                eBIT_H2: begin
                    // Registered pulse lands on the final clock of the last half-symbol.
                    if (half_cnt == HALF_PRE && bit_idx == IDX_LAST) begin
                        TX_DONE <= 1'b1;
                    end
                    if (half_end) begin
                        half_cnt <= '0;
                        if (bit_idx != IDX_LAST) begin
                            shift_reg <= shift_nxt;
                            bit_idx   <= bit_idx + IW'(1);
                            TXD       <= ~shift_nxt[0];
                            state     <= eBIT_H1;
                        end else begin
                            // The entry clock is the first idle-high clock of the gap.
                            gap_cnt <= GW'(1);
                            TXD     <= 1'b1;
                            state   <= eGAP;
                        end
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                eGAP: begin
                    TXD <= 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        MSG_RDY <= 1'b1;
                        TX_BUSY <= 1'b0;
                        state   <= eIDLE;
                    end else if (gap_cnt != GAP_MAX) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    half_cnt <= '0;
                    gap_cnt  <= '0;
                    TXD      <= 1'b1;
                    MSG_RDY  <= 1'b0;
                    TX_BUSY  <= 1'b1;
                    state    <= eGAP;
                end
            endcase
        end
    end

endmodule
